// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: loader FSM state encoding and byte-packing constants
package inst_loader_pkg;
  typedef enum logic [1:0] {LD_IDLE = 2'b00, LD_LOAD = 2'b01, LD_RUN = 2'b10} ld_state_t;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/inst_loader_ram.sv
// inst_loader_ram: instruction RAM, sync write port, async read port (we/waddr/wdata, raddr/rdata)
module inst_loader_ram #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/inst_loader.sv
// inst_loader: byte-stream program loader, core reset control and zero-latency gated instruction read
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  input  logic                  rom_ce,
  input  logic [31:0]           rom_addr_i,
  output logic [31:0]           rom_data_o,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   word_count,
  output logic                  err
);
  localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
  ld_state_t state, state_n;
  logic [1:0] idx, idx_n;
  logic [23:0] shreg, shreg_n;
  logic [DEPTH_LOG2:0] wc_n;
  logic err_n, we, accept, full, last_byte, rd_ok, unused_addr;
  logic [DEPTH_LOG2-1:0] ridx;
  logic [31:0] rdata;
  assign accept = state == LD_LOAD && ld_valid;
  assign full = word_count == DEPTH;
  assign last_byte = idx == 2'(BYTES_PER_WORD - 1);
  // earlier bytes sit in shreg; the current byte completes the word in place
  always_comb begin
    state_n = state;
    idx_n = idx;
    shreg_n = shreg;
    wc_n = word_count;
    err_n = err;
    we = 1'b0;
    if (state != LD_LOAD && load_start) begin
      state_n = LD_LOAD;
      idx_n = '0;
      shreg_n = '0;
      wc_n = '0;
      err_n = 1'b0;
    end else if (accept) begin
      if (full) begin
        err_n = 1'b1;
        state_n = LD_IDLE;
      end else if (last_byte) begin
        we = 1'b1;
        wc_n = word_count + 1'b1;
        idx_n = '0;
        shreg_n = '0;
        state_n = ld_last ? LD_RUN : LD_LOAD;
      end else if (ld_last) begin
        err_n = 1'b1;
        idx_n = '0;
        shreg_n = '0;
        state_n = LD_IDLE;
      end else begin
        idx_n = idx + 2'd1;
        shreg_n = {shreg[15:0], ld_data};
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LD_IDLE;
      idx <= '0;
      shreg <= '0;
      word_count <= '0;
      err <= 1'b0;
      cpu_rst <= 1'b1;
    end else begin
      state <= state_n;
      idx <= idx_n;
      shreg <= shreg_n;
      word_count <= wc_n;
      err <= err_n;
      cpu_rst <= state_n != LD_RUN;
    end
  end
  assign ld_ready = state == LD_LOAD;
  assign busy = state == LD_LOAD;
  assign ridx = rom_addr_i[DEPTH_LOG2+1:2];
  assign unused_addr = ^rom_addr_i[1:0];
  assign rd_ok = state == LD_RUN && rom_ce && {1'b0, ridx} < word_count && rom_addr_i[31:DEPTH_LOG2+2] == '0;
  assign rom_data_o = rd_ok ? rdata : 32'h0;
  inst_loader_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(word_count[DEPTH_LOG2-1:0]),
    .wdata({shreg, ld_data}),
    .raddr(ridx),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed scoreboard bench for inst_loader at a 4-word RAM depth
module tb_inst_loader;
  localparam int DL = 2;
  logic clk = 1'b0, rst = 1'b1, load_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0, rom_ce = 1'b0;
  logic [7:0] ld_data = '0;
  logic [31:0] rom_addr_i = '0;
  logic ld_ready, cpu_rst, busy, err;
  logic [31:0] rom_data_o;
  logic [DL:0] word_count;
  int checks = 0, failures = 0;
  typedef struct {
    string name;
    int sel;
    logic [31:0] exp;
  } item_t;
  item_t q[$];

  inst_loader #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .rom_ce(rom_ce), .rom_addr_i(rom_addr_i),
    .rom_data_o(rom_data_o), .cpu_rst(cpu_rst), .busy(busy), .word_count(word_count), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] actual(int sel);
    case (sel)
      0: return rom_data_o;
      1: return {31'b0, cpu_rst};
      2: return {31'b0, busy};
      3: return {31'b0, ld_ready};
      4: return {31'b0, err};
      5: return {{(31-DL){1'b0}}, word_count};
      default: return dut.u_ram.mem[sel-6];
    endcase
  endfunction

  always @(negedge clk)
    while (q.size() > 0) begin
      item_t it;
      logic [31:0] a;
      it = q.pop_front();
      a = actual(it.sel);
      checks++;
      if (a !== it.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", it.name, a, it.exp);
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(string n, int sel, logic [31:0] v);
    q.push_back('{n, sel, v});
  endtask

  task automatic status(string n, bit c, bit b, bit r, bit e, int wc);
    expect_v({n, ".cpu_rst"}, 1, 32'(c));
    expect_v({n, ".busy"}, 2, 32'(b));
    expect_v({n, ".ld_ready"}, 3, 32'(r));
    expect_v({n, ".err"}, 4, 32'(e));
    expect_v({n, ".word_count"}, 5, 32'(wc));
    tick();
  endtask

  task automatic rd(string n, bit ce, logic [31:0] addr, logic [31:0] v);
    rom_ce = ce;
    rom_addr_i = addr;
    expect_v(n, 0, v);
    tick();
    rom_ce = 1'b0;
  endtask

  task automatic start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send(logic [7:0] b, bit last, int gap);
    for (int i = 0; i < gap; i++) begin
      expect_v("gap_busy", 2, 32'd1);
      tick();
    end
    ld_valid = 1'b1;
    ld_data = b;
    ld_last = last;
    for (int i = 0; i < 20 && !ld_ready; i++) tick();
    checks++;
    if (!ld_ready) begin
      failures++;
      $display("FAIL ready_timeout: got ld_ready=%b expected 1", ld_ready);
    end
    tick();
    ld_valid = 1'b0;
    ld_last = 1'b0;
  endtask

  task automatic send_seq(logic [7:0] bytes[$], bit with_last, bit gaps);
    foreach (bytes[i]) send(bytes[i], with_last && i == bytes.size() - 1, gaps ? i % 4 : 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    status("reset", 1, 0, 0, 0, 0);
    rst = 1'b0;
    // 1: two-word load
    start();
    status("t1_load", 1, 1, 1, 0, 0);
    send_seq('{8'h34, 8'h01, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 0);
    status("t1_run", 0, 0, 0, 0, 2);
    rd("t1_a0", 1, 32'h0, 32'h34010010);
    rd("t1_a4", 1, 32'h4, 32'h0);
    rd("t1_a8", 1, 32'h8, 32'h0);
    rd("t1_hi", 1, 32'h10, 32'h0);
    rd("t1_ce0", 0, 32'h0, 32'h0);
    // 2 and 6: reload from RUN with gapped bytes
    start();
    status("t2_load", 1, 1, 1, 0, 0);
    rd("t2_load_rd", 1, 32'h0, 32'h0);
    send_seq('{8'h34, 8'h01, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 1);
    status("t2_run", 0, 0, 0, 0, 2);
    rd("t2_a1", 1, 32'h1, 32'h34010010);
    rd("t2_a2", 1, 32'h2, 32'h34010010);
    rd("t2_a3", 1, 32'h3, 32'h34010010);
    // 3: short final word
    start();
    send_seq('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}, 1, 0);
    status("t3_short", 1, 0, 0, 1, 1);
    rd("t3_idle_rd", 1, 32'h0, 32'h0);
    start();
    status("t3_clear", 1, 1, 1, 0, 0);
    // 4: overflow at 4 words
    send_seq('{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
               8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0, 8'hD1, 8'hD2, 8'hD3}, 0, 0);
    status("t4_full", 1, 1, 1, 0, 4);
    send(8'hEE, 1'b0, 0);
    status("t4_ovf", 1, 0, 0, 1, 4);
    expect_v("t4_mem0", 6, 32'hA0A1A2A3);
    expect_v("t4_mem1", 7, 32'hB0B1B2B3);
    expect_v("t4_mem2", 8, 32'hC0C1C2C3);
    expect_v("t4_mem3", 9, 32'hD0D1D2D3);
    tick();
    // 5: reset mid-load
    start();
    send_seq('{8'h5A, 8'h5B, 8'h5C, 8'h5D, 8'h5E}, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    status("t5_rst", 1, 0, 0, 0, 0);
    start();
    send_seq('{8'h0F, 8'h1E, 8'h2D, 8'h3C}, 1, 0);
    status("t5_run", 0, 0, 0, 0, 1);
    rd("t5_a0", 1, 32'h0, 32'h0F1E2D3C);
    rd("t5_a4", 1, 32'h4, 32'h0);
    // 6: reload from RUN
    start();
    expect_v("t6_cpu_rst", 1, 32'd1);
    expect_v("t6_busy", 2, 32'd1);
    rd("t6_rd0", 1, 32'h0, 32'h0);
    rd("t6_rd4", 1, 32'h4, 32'h0);
    send_seq('{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67}, 1, 0);
    status("t6_run", 0, 0, 0, 0, 2);
    rd("t6_a0", 1, 32'h0, 32'hDEADBEEF);
    rd("t6_a4", 1, 32'h4, 32'h01234567);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
